// File: rtl/control_pipeline.sv
// Pipelined MIPS control unit: decodes the opcode in ID, carries the control
// bundle through the ID/EX, EX/MEM and MEM/WB registers, and generates the
// load-use stall, branch/jump redirect and flush controls for the datapath.
module control_pipeline #(
    parameter int unsigned ALUOP_W   = 2,
    parameter bit          HAZARD_EN = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic               ex_zero,
    output logic               ex_RegDst,
    output logic               ex_ALUSrc,
    output logic               ex_Ori,
    output logic [ALUOP_W-1:0] ex_ALUOp,
    output logic               mem_MemRead,
    output logic               mem_MemWrite,
    output logic               wb_RegWrite,
    output logic               wb_MemtoReg,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               if_flush,
    output logic [1:0]         pc_sel,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam logic [5:0] OP_R   = 6'd0;
    localparam logic [5:0] OP_J   = 6'd2;
    localparam logic [5:0] OP_BEQ = 6'd4;
    localparam logic [5:0] OP_BNE = 6'd5;
    localparam logic [5:0] OP_ORI = 6'd13;
    localparam logic [5:0] OP_LW  = 6'd35;
    localparam logic [5:0] OP_SW  = 6'd43;

    localparam logic [1:0] SEL_PC4    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;

    // Control fields that are still needed once the instruction is in EX.
    // Jump is consumed in ID and is therefore not carried forward.
    typedef struct packed {
        logic               reg_dst;
        logic               alu_src;
        logic               ori;
        logic [ALUOP_W-1:0] alu_op;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               memto_reg;
        logic               beq;
        logic               bne;
    } ex_ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic memto_reg;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic memto_reg;
    } wb_ctrl_t;

    ex_ctrl_t   id_ctrl_s;
    logic       id_jump_s;
    logic       id_legal_s;
    logic       branch_taken_s;
    logic       load_use_s;
    logic       stall_s;
    logic       jump_s;
    logic       flush_evt_s;

    ex_ctrl_t   idex_q,  idex_d;
    logic [4:0] idex_rt_q, idex_rt_d;
    mem_ctrl_t  exmem_q, exmem_d;
    wb_ctrl_t   memwb_q, memwb_d;
    logic       illegal_q, illegal_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Opcode decode; unimplemented opcodes produce a bubble and clear legal.
    always_comb begin
        id_ctrl_s  = '0;
        id_jump_s  = 1'b0;
        id_legal_s = 1'b1;
        case (opcode)
            OP_R: begin
                id_ctrl_s.reg_dst   = 1'b1;
                id_ctrl_s.reg_write = 1'b1;
                id_ctrl_s.alu_op    = ALUOP_W'(2'b10);
            end
            OP_ORI: begin
                id_ctrl_s.alu_src   = 1'b1;
                id_ctrl_s.reg_write = 1'b1;
                id_ctrl_s.ori       = 1'b1;
            end
            OP_LW: begin
                id_ctrl_s.alu_src   = 1'b1;
                id_ctrl_s.memto_reg = 1'b1;
                id_ctrl_s.reg_write = 1'b1;
                id_ctrl_s.mem_read  = 1'b1;
            end
            OP_SW: begin
                id_ctrl_s.alu_src   = 1'b1;
                id_ctrl_s.mem_write = 1'b1;
            end
            OP_BEQ: begin
                id_ctrl_s.beq    = 1'b1;
                id_ctrl_s.alu_op = ALUOP_W'(2'b01);
            end
            OP_BNE: begin
                id_ctrl_s.bne    = 1'b1;
                id_ctrl_s.alu_op = ALUOP_W'(2'b01);
            end
            OP_J: begin
                id_jump_s        = 1'b1;
                id_ctrl_s.alu_op = ALUOP_W'(2'b01);
            end
            default: begin
                id_legal_s = 1'b0;
            end
        endcase
    end

    // Hazard resolution: taken branch beats load-use stall, which beats jump.
    always_comb begin
        branch_taken_s = (idex_q.beq & ex_zero) | (idex_q.bne & ~ex_zero);
        load_use_s     = 1'b0;
        if ((HAZARD_EN == 1'b1) && idex_q.mem_read && (idex_rt_q != 5'd0) &&
            ((idex_rt_q == id_rs) || (idex_rt_q == id_rt))) begin
            load_use_s = 1'b1;
        end else begin
            load_use_s = 1'b0;
        end
        // The ID instruction is wrong-path under a taken branch, so never stall on it.
        stall_s     = load_use_s & ~branch_taken_s;
        jump_s      = id_jump_s & ~branch_taken_s & ~stall_s;
        flush_evt_s = branch_taken_s | jump_s;
    end

    // PC / IF-ID steering for the current cycle.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        if_flush   = 1'b0;
        pc_sel     = SEL_PC4;
        if (branch_taken_s) begin
            pc_sel   = SEL_BRANCH;
            if_flush = 1'b1;
        end else if (stall_s) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (jump_s) begin
            pc_sel   = SEL_JUMP;
            if_flush = 1'b1;
        end else begin
            pc_sel = SEL_PC4;
        end
    end

    // Next state of the stage registers, sticky flag and event counters.
    always_comb begin
        idex_d    = id_ctrl_s;
        idex_rt_d = id_rt;
        if (branch_taken_s || stall_s || !id_legal_s) begin
            idex_d    = '0;
            idex_rt_d = 5'd0;
        end else begin
            idex_d    = id_ctrl_s;
            idex_rt_d = id_rt;
        end

        exmem_d.mem_read  = idex_q.mem_read;
        exmem_d.mem_write = idex_q.mem_write;
        exmem_d.reg_write = idex_q.reg_write;
        exmem_d.memto_reg = idex_q.memto_reg;

        memwb_d.reg_write = exmem_q.reg_write;
        memwb_d.memto_reg = exmem_q.memto_reg;

        illegal_d = illegal_q | (~id_legal_s & ~branch_taken_s & ~stall_s);

        if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end

        if (flush_evt_s && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Stage registers and status; reset returns every stage to a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q      <= '0;
            idex_rt_q   <= 5'd0;
            exmem_q     <= '0;
            memwb_q     <= '0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            idex_q      <= idex_d;
            idex_rt_q   <= idex_rt_d;
            exmem_q     <= exmem_d;
            memwb_q     <= memwb_d;
            illegal_q   <= illegal_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_RegDst    = idex_q.reg_dst;
    assign ex_ALUSrc    = idex_q.alu_src;
    assign ex_Ori       = idex_q.ori;
    assign ex_ALUOp     = idex_q.alu_op;
    assign mem_MemRead  = exmem_q.mem_read;
    assign mem_MemWrite = exmem_q.mem_write;
    assign wb_RegWrite  = memwb_q.reg_write;
    assign wb_MemtoReg  = memwb_q.memto_reg;
    assign illegal_op   = illegal_q;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_control_pipeline.sv
// Testbench for control_pipeline: directed vector table, randomized run against
// a table-lookup pipeline model, and a counter saturation sequence on a CNT_W=2 copy.
module tb_control_pipeline;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       ex_zero;

    // Outputs of the default-parameter instance (a_*) and the CNT_W=2 instance (b_*).
    logic a_RegDst, a_ALUSrc, a_Ori, a_MemRead, a_MemWrite, a_RegWrite, a_MemtoReg;
    logic a_pc_write, a_ifid_write, a_if_flush, a_illegal;
    logic [1:0]  a_ALUOp, a_pc_sel;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    logic b_RegDst, b_ALUSrc, b_Ori, b_MemRead, b_MemWrite, b_RegWrite, b_MemtoReg;
    logic b_pc_write, b_ifid_write, b_if_flush, b_illegal;
    logic [1:0]  b_ALUOp, b_pc_sel;
    logic [1:0]  b_stall_cnt, b_flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_pipeline dut (
        .clk(clk), .rst(rst), .opcode(opcode), .id_rs(id_rs), .id_rt(id_rt), .ex_zero(ex_zero),
        .ex_RegDst(a_RegDst), .ex_ALUSrc(a_ALUSrc), .ex_Ori(a_Ori), .ex_ALUOp(a_ALUOp),
        .mem_MemRead(a_MemRead), .mem_MemWrite(a_MemWrite),
        .wb_RegWrite(a_RegWrite), .wb_MemtoReg(a_MemtoReg),
        .pc_write(a_pc_write), .ifid_write(a_ifid_write), .if_flush(a_if_flush), .pc_sel(a_pc_sel),
        .illegal_op(a_illegal), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    control_pipeline #(.ALUOP_W(2), .HAZARD_EN(1'b1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .opcode(opcode), .id_rs(id_rs), .id_rt(id_rt), .ex_zero(ex_zero),
        .ex_RegDst(b_RegDst), .ex_ALUSrc(b_ALUSrc), .ex_Ori(b_Ori), .ex_ALUOp(b_ALUOp),
        .mem_MemRead(b_MemRead), .mem_MemWrite(b_MemWrite),
        .wb_RegWrite(b_RegWrite), .wb_MemtoReg(b_MemtoReg),
        .pc_write(b_pc_write), .ifid_write(b_ifid_write), .if_flush(b_if_flush), .pc_sel(b_pc_sel),
        .illegal_op(b_illegal), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    logic [14:0] obs_a, obs_b;
    logic [10:0] tab_obs;
    assign obs_a = {a_RegDst, a_ALUSrc, a_Ori, a_ALUOp, a_MemRead, a_MemWrite, a_RegWrite, a_MemtoReg,
                    a_pc_write, a_ifid_write, a_if_flush, a_pc_sel, a_illegal};
    assign obs_b = {b_RegDst, b_ALUSrc, b_Ori, b_ALUOp, b_MemRead, b_MemWrite, b_RegWrite, b_MemtoReg,
                    b_pc_write, b_ifid_write, b_if_flush, b_pc_sel, b_illegal};
    // pc_write ifid_write if_flush pc_sel ex_ALUOp ex_RegDst mem_MemRead wb_MemtoReg illegal_op
    assign tab_obs = {a_pc_write, a_ifid_write, a_if_flush, a_pc_sel, a_ALUOp,
                      a_RegDst, a_MemRead, a_MemtoReg, a_illegal};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at time %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each stage holds the 12-bit decode-table row of its instruction:
    // [11]RegDst [10]ALUSrc [9]MemtoReg [8]RegWrite [7]MemRead [6]MemWrite
    // [5]Ori [4]Beq [3]Bne [2]Jump [1:0]ALUOp ; bubble = 0.
    logic [11:0] m_ex, m_mem, m_wb;
    logic [4:0]  m_ex_rt;
    bit          m_ill;
    bit          m_valid = 1'b0;
    int          m_stall_a, m_flush_a, m_stall_b, m_flush_b;

    // Returns {legal, table row}.
    function automatic logic [12:0] tbl(input logic [5:0] op);
        case (op)
            6'd0:    return {1'b1, 12'b100100000010};
            6'd13:   return {1'b1, 12'b010100100000};
            6'd35:   return {1'b1, 12'b011110000000};
            6'd43:   return {1'b1, 12'b010001000000};
            6'd4:    return {1'b1, 12'b000000010001};
            6'd5:    return {1'b1, 12'b000000001001};
            6'd2:    return {1'b1, 12'b000000000101};
            default: return 13'd0;
        endcase
    endfunction

    // Returns {taken, stall, jump} for the current cycle.
    function automatic logic [2:0] events();
        logic [12:0] d;
        logic tk, hz, jp;
        d  = tbl(opcode);
        tk = (m_ex[4] && ex_zero) || (m_ex[3] && !ex_zero);
        hz = m_ex[7] && (m_ex_rt != 5'd0) && ((m_ex_rt == id_rs) || (m_ex_rt == id_rt)) && !tk;
        jp = d[2] && !tk && !hz;
        return {tk, hz, jp};
    endfunction

    task automatic model_check();
        logic [2:0]  ev;
        logic [1:0]  sel;
        logic [14:0] exp;
        ev  = events();
        sel = ev[2] ? 2'b01 : (ev[0] ? 2'b10 : 2'b00);
        exp = {m_ex[11], m_ex[10], m_ex[5], m_ex[1:0], m_mem[7], m_mem[6], m_wb[8], m_wb[9],
               !ev[1], !ev[1], ev[2] || ev[0], sel, m_ill};
        check("outputs_a", 64'(obs_a), 64'(exp));
        check("outputs_b", 64'(obs_b), 64'(exp));
        check("stall_cnt_a", 64'(a_stall_cnt), 64'(m_stall_a));
        check("flush_cnt_a", 64'(a_flush_cnt), 64'(m_flush_a));
        check("stall_cnt_b", 64'(b_stall_cnt), 64'(m_stall_b));
        check("flush_cnt_b", 64'(b_flush_cnt), 64'(m_flush_b));
    endtask

    task automatic model_step();
        logic [2:0]  ev;
        logic [12:0] d;
        if (rst) begin
            m_ex = 12'd0; m_mem = 12'd0; m_wb = 12'd0; m_ex_rt = 5'd0; m_ill = 1'b0;
            m_stall_a = 0; m_flush_a = 0; m_stall_b = 0; m_flush_b = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            ev = events();
            d  = tbl(opcode);
            if (ev[1]) begin
                if (m_stall_a < 65535) m_stall_a++;
                if (m_stall_b < 3)     m_stall_b++;
            end
            if (ev[2] || ev[0]) begin
                if (m_flush_a < 65535) m_flush_a++;
                if (m_flush_b < 3)     m_flush_b++;
            end
            if (!d[12] && !ev[2] && !ev[1]) m_ill = 1'b1;
            m_wb  = m_mem;
            m_mem = m_ex;
            if (ev[2] || ev[1] || !d[12]) begin
                m_ex = 12'd0; m_ex_rt = 5'd0;
            end else begin
                m_ex = d[11:0]; m_ex_rt = id_rt;
            end
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] op, input logic [4:0] s,
                         input logic [4:0] t, input logic z);
        rst = r; opcode = op; id_rs = s; id_rt = t; ex_zero = z;
        @(negedge clk);
        if (m_valid) model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cycle(input logic r, input logic [5:0] op, input logic [4:0] s,
                         input logic [4:0] t, input logic z);
        drive(r, op, s, t, z);
        advance();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        r;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        z;
        logic        chk;
        logic [10:0] obs;
        int          scnt;
        int          fcnt;
    } vec_t;

    localparam int NV = 28;
    vec_t vt [NV];

    task automatic setv(input int i, input logic r, input logic [5:0] op, input logic [4:0] s,
                        input logic [4:0] t, input logic z, input logic c, input logic [10:0] o,
                        input int sc, input int fc);
        vt[i].r = r; vt[i].op = op; vt[i].rs = s; vt[i].rt = t; vt[i].z = z;
        vt[i].chk = c; vt[i].obs = o; vt[i].scnt = sc; vt[i].fcnt = fc;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; opcode = 6'd35; id_rs = 5'd0; id_rt = 5'd0; ex_zero = 1'b0;
        //        r   op     rs     rt     z     chk   pw iw fl sel alu rd mr mtr il  stall flush
        setv( 0, 1'b1, 6'd35, 5'd0,  5'd0,  1'b0, 1'b0, 11'b1_1_0_00_00_0_0_0_0, 0, 0);
        setv( 1, 1'b1, 6'd35, 5'd0,  5'd0,  1'b0, 1'b1, 11'b1_1_0_00_00_0_0_0_0, 0, 0);
        setv( 2, 1'b0, 6'd0,  5'd1,  5'd2,  1'b0, 1'b1, 11'b1_1_0_00_00_0_0_0_0, 0, 0);
        setv( 3, 1'b0, 6'd13, 5'd3,  5'd4,  1'b0, 1'b1, 11'b1_1_0_00_10_1_0_0_0, 0, 0);
        setv( 4, 1'b0, 6'd35, 5'd5,  5'd6,  1'b0, 1'b1, 11'b1_1_0_00_00_0_0_0_0, 0, 0);
        setv( 5, 1'b0, 6'd43, 5'd7,  5'd9,  1'b0, 1'b1, 11'b1_1_0_00_00_0_0_0_0, 0, 0);
        setv( 6, 1'b0, 6'd0,  5'd10, 5'd11, 1'b0, 1'b1, 11'b1_1_0_00_00_0_1_0_0, 0, 0);
        setv( 7, 1'b0, 6'd0,  5'd12, 5'd13, 1'b0, 1'b1, 11'b1_1_0_00_10_1_0_1_0, 0, 0);
        setv( 8, 1'b0, 6'd35, 5'd1,  5'd8,  1'b0, 1'b1, 11'b1_1_0_00_10_1_0_0_0, 0, 0);
        setv( 9, 1'b0, 6'd0,  5'd8,  5'd3,  1'b0, 1'b1, 11'b0_0_0_00_00_0_0_0_0, 0, 0);
        setv(10, 1'b0, 6'd0,  5'd8,  5'd3,  1'b0, 1'b1, 11'b1_1_0_00_00_0_1_0_0, 1, 0);
        setv(11, 1'b0, 6'd35, 5'd2,  5'd0,  1'b0, 1'b1, 11'b1_1_0_00_10_1_0_1_0, 1, 0);
        setv(12, 1'b0, 6'd0,  5'd0,  5'd0,  1'b0, 1'b1, 11'b1_1_0_00_00_0_0_0_0, 1, 0);
        setv(13, 1'b0, 6'd4,  5'd1,  5'd2,  1'b0, 1'b1, 11'b1_1_0_00_10_1_1_0_0, 1, 0);
        setv(14, 1'b0, 6'd0,  5'd3,  5'd4,  1'b1, 1'b1, 11'b1_1_1_01_01_0_0_1_0, 1, 0);
        setv(15, 1'b0, 6'd5,  5'd1,  5'd2,  1'b0, 1'b1, 11'b1_1_0_00_00_0_0_0_0, 1, 1);
        setv(16, 1'b0, 6'd2,  5'd0,  5'd0,  1'b1, 1'b1, 11'b1_1_1_10_01_0_0_0_0, 1, 1);
        setv(17, 1'b0, 6'd4,  5'd0,  5'd0,  1'b0, 1'b1, 11'b1_1_0_00_01_0_0_0_0, 1, 2);
        setv(18, 1'b0, 6'd2,  5'd0,  5'd0,  1'b1, 1'b1, 11'b1_1_1_01_01_0_0_0_0, 1, 2);
        setv(19, 1'b0, 6'd63, 5'd0,  5'd0,  1'b0, 1'b1, 11'b1_1_0_00_00_0_0_0_0, 1, 3);
        setv(20, 1'b0, 6'd0,  5'd1,  5'd2,  1'b0, 1'b1, 11'b1_1_0_00_00_0_0_0_1, 1, 3);
        setv(21, 1'b0, 6'd0,  5'd1,  5'd2,  1'b0, 1'b1, 11'b1_1_0_00_10_1_0_0_1, 1, 3);
        setv(22, 1'b1, 6'd35, 5'd0,  5'd0,  1'b0, 1'b1, 11'b1_1_0_00_10_1_0_0_1, 1, 3);
        setv(23, 1'b0, 6'd0,  5'd1,  5'd2,  1'b0, 1'b1, 11'b1_1_0_00_00_0_0_0_0, 0, 0);
        setv(24, 1'b0, 6'd35, 5'd1,  5'd5,  1'b0, 1'b1, 11'b1_1_0_00_10_1_0_0_0, 0, 0);
        setv(25, 1'b0, 6'd2,  5'd5,  5'd0,  1'b0, 1'b1, 11'b0_0_0_00_00_0_0_0_0, 0, 0);
        setv(26, 1'b0, 6'd2,  5'd5,  5'd0,  1'b0, 1'b1, 11'b1_1_1_10_00_0_1_0_0, 1, 0);
        setv(27, 1'b0, 6'd0,  5'd0,  5'd0,  1'b0, 1'b1, 11'b1_1_0_00_01_0_0_1_0, 1, 1);

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].r, vt[i].op, vt[i].rs, vt[i].rt, vt[i].z);
            if (vt[i].chk) begin
                check($sformatf("vec%0d_ctl", i), 64'(tab_obs), 64'(vt[i].obs));
                check($sformatf("vec%0d_stall_cnt", i), 64'(a_stall_cnt), 64'(vt[i].scnt));
                check($sformatf("vec%0d_flush_cnt", i), 64'(a_flush_cnt), 64'(vt[i].fcnt));
            end
            advance();
        end

        // Randomized traffic with small register numbers so hazards are frequent.
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] op;
            int k;
            k = int'($urandom_range(0, 7));
            case (k)
                0: op = 6'd0;
                1: op = 6'd13;
                2: op = 6'd35;
                3: op = 6'd43;
                4: op = 6'd4;
                5: op = 6'd5;
                6: op = 6'd2;
                default: op = 6'($urandom_range(0, 63));
            endcase
            cycle(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, op,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Five separate load-use stalls: the 2-bit counter must stop at 3.
        cycle(1'b1, 6'd0, 5'd0, 5'd0, 1'b0);
        for (int s = 0; s < 5; s++) begin
            cycle(1'b0, 6'd35, 5'd0, 5'd7, 1'b0);
            cycle(1'b0, 6'd0,  5'd7, 5'd0, 1'b0);
            cycle(1'b0, 6'd0,  5'd7, 5'd0, 1'b0);
        end
        drive(1'b0, 6'd0, 5'd0, 5'd0, 1'b0);
        check("sat_stall_cnt_w16", 64'(a_stall_cnt), 64'd5);
        check("sat_stall_cnt_w2", 64'(b_stall_cnt), 64'd3);
        check("sat_flush_cnt_w2", 64'(b_flush_cnt), 64'd0);
        advance();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_pipeline.md
Name: control_pipeline

Overview:
Five-stage pipelined successor to the single-cycle MIPS control unit. Decodes opcode in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB control registers. Detects load-use hazards and branch/jump redirects, and drives the stall and flush signals. Sits beside the pipelined datapath, replacing per-instruction combinational control.

Parameters:
ALUOP_W, 2, width of the ALUOp field sent to the ALU control.
HAZARD_EN, 1, 1 = load-use stall logic active; 0 = stall never asserted (forwarding-only or compiler-scheduled builds).
CNT_W, 16, width of the saturating stall and flush performance counters.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
opcode  in  6  ID-stage instruction opcode
id_rs  in  5  ID-stage rs field
id_rt  in  5  ID-stage rt field
ex_zero  in  1  ALU zero flag of the instruction in EX
ex_RegDst, ex_ALUSrc, ex_Ori  out  1  EX-stage controls
ex_ALUOp  out  ALUOP_W  EX-stage ALU operation class
mem_MemRead, mem_MemWrite  out  1  MEM-stage controls
wb_RegWrite, wb_MemtoReg  out  1  WB-stage controls
pc_write  out  1  PC register enable
ifid_write  out  1  IF/ID register enable
if_flush  out  1  zero the IF/ID register on the next edge
pc_sel  out  2  00 PC+4, 01 branch target (EX), 10 jump target (ID)
illegal_op  out  1  sticky; an unimplemented opcode reached ID
stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Behaviour:
- Synchronous, active-high reset. Clears all stage registers to the bubble (all fields 0, including the registered rt and Beq/Bne/MemRead). Clears illegal_op and both counters. After reset: pc_write=1, ifid_write=1, if_flush=0, pc_sel=00.
- Decode table, for fields RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite Ori Beq Bne Jump ALUOp:
  - R(0): 1 0 0 1 0 0 0 0 0 0 10
  - ORI(13): 0 1 0 1 0 0 1 0 0 0 00
  - LW(35): 0 1 1 1 1 0 0 0 0 0 00
  - SW(43): 0 1 0 0 0 1 0 0 0 0 00
  - BEQ(4): 0 0 0 0 0 0 0 1 0 0 01
  - BNE(5): 0 0 0 0 0 0 0 0 1 0 01
  - J(2): 0 0 0 0 0 0 0 0 0 1 01
  - Don't-cares are driven as 0; no X is ever propagated.
  - Any other opcode decodes to a bubble and sets illegal_op on that edge, unless a stall or flush suppresses ID.
  - ALUOp is zero-extended to ALUOP_W.
- Pipeline advance every edge: ID/EX <= decoded bundle (or bubble), EX/MEM <= EX fields, MEM/WB <= MEM fields.
- Latency: an instruction decoded in cycle n drives its ex_* outputs in n+1, mem_* in n+2 and wb_* in n+3.
- Load-use stall (HAZARD_EN=1):
  - Condition: ex MemRead=1, ex rt!=0, and (ex rt==id_rs or ex rt==id_rt).
  - Response: pc_write=0, ifid_write=0, and a bubble is inserted into ID/EX.
  - Lasts exactly one cycle.
  - A stall is never raised against an ID instruction that is being flushed.
- Branch, resolved in EX:
  - Taken when (ex Beq & ex_zero) | (ex Bne & ~ex_zero).
  - Response: pc_sel=01, if_flush=1, a bubble into ID/EX, and pc_write=1.
  - Penalty: 2 cycles.
- Jump, resolved in ID:
  - When ID Jump=1 and the cycle is neither stalled nor branch-flushed: pc_sel=10, if_flush=1.
  - Penalty: 1 cycle. The J bundle itself continues down the pipeline as a harmless no-write.
- Priority per cycle: taken branch > load-use stall > jump > normal. Consequences:
  - A taken branch cancels a coincident stall and a coincident jump.
  - A jump in ID during a stall waits and redirects in the following cycle.
- Counters:
  - stall_cnt increments once per cycle that a stall is applied.
  - flush_cnt increments once per cycle with if_flush=1.
  - Both saturate at 2^CNT_W-1 with no wrap.
- Reset asserted mid-stream: the next edge discards all in-flight controls, and outputs equal the post-reset values.

Test Plan:
1. Reset with rst=1 for 2 cycles while opcode=35 → all stage outputs 0, pc_write=1, counters 0, illegal_op=0.
2. Sequence R, ORI, LW, SW with independent registers → ex_ALUOp 10,00,00,00 on successive cycles; wb_MemtoReg=1 exactly 3 cycles after LW enters ID; no stall.
3. LW rt=8, then R with id_rs=8 → one stall cycle (pc_write=0, ifid_write=0, bubble in EX), stall_cnt=1; the R bundle reaches EX one cycle late. Repeat with rt=0 → no stall.
4. BEQ with ex_zero=1 → pc_sel=01, if_flush=1, ex_* bubble next cycle, flush_cnt=1. BNE with ex_zero=1 → not taken, pc_sel=00.
5. J in ID coinciding with a taken branch in EX → pc_sel=01 only, jump suppressed. J alone → pc_sel=10 for one cycle.
6. opcode=63 → bubble into EX, illegal_op=1 and sticky until rst. CNT_W=2 bench with 5 stalls → stall_cnt saturates at 3.
